up_stream_ctrl: RTL and testbench



---
 rtl/up_stream_ctrl_if.sv | 32 +++
 rtl/up_stream_ctrl.sv | 100 ++++++++++
 tb/tb_up_stream_ctrl.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/up_stream_ctrl_if.sv
// Handshake bundle between the upsampling playback sequencer and its FIFO/DAC neighbours.
// master: the surrounding datapath/stimulus side; slave: the sequencer itself.
interface up_stream_ctrl_if #(
  parameter int CNT_WIDTH = 7
);
  logic                 start;
  logic                 stop;
  logic [CNT_WIDTH-1:0] fifo_count;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic                 wr_en;
  logic                 rd_en;
  logic                 interp_ena;
  logic                 dac_mute;
  logic                 dac_sleep;
  logic [1:0]           state;
  logic                 busy;
  logic [7:0]           underrun_cnt;
  logic [7:0]           overflow_cnt;

  modport master (
    output start, stop, fifo_count, fifo_empty, fifo_full, wr_en,
    input  rd_en, interp_ena, dac_mute, dac_sleep, state, busy,
           underrun_cnt, overflow_cnt
  );

  modport slave (
    input  start, stop, fifo_count, fifo_empty, fifo_full, wr_en,
    output rd_en, interp_ena, dac_mute, dac_sleep, state, busy,
           underrun_cnt, overflow_cnt
  );
endinterface

// File: rtl/up_stream_ctrl.sv
// Playback sequencer: prefills the FIFO, paces reads at one per 2^SAMPLE_RATE clocks,
// gates the interpolator, mutes the DAC on underrun and drains the FIFO on stop.
module up_stream_ctrl #(
  parameter int FIFO_DEPTH    = 64,
  parameter int CNT_WIDTH     = 7,
  parameter int SAMPLE_RATE   = 4,
  parameter int PREFILL_LEVEL = 32
) (
  input logic           clk,
  input logic           rst,
  up_stream_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREFILL = 2'd1,
    RUN     = 2'd2,
    DRAIN   = 2'd3
  } state_t;

  // Out-of-range prefill levels can never be satisfied, so PREFILL is never left.
  localparam bit PREFILL_LEGAL = (PREFILL_LEVEL >= 1) && (PREFILL_LEVEL <= FIFO_DEPTH);

  state_t                 st;
  state_t                 next_st;
  logic [SAMPLE_RATE-1:0] phase;
  logic                   slot;
  logic                   prefill_met;
  logic                   rd_req;
  logic                   underrun;

  assign slot        = (phase == '1);
  assign prefill_met = PREFILL_LEGAL &&
                       (32'(bus.fifo_count) >= 32'(PREFILL_LEVEL));
  assign bus.state   = st;

  always_comb begin
    next_st  = st;
    rd_req   = 1'b0;
    underrun = 1'b0;
    case (st)
      IDLE: begin
        if (bus.start && !bus.stop) next_st = PREFILL;
      end
      PREFILL: begin
        if (bus.stop)         next_st = IDLE;
        else if (prefill_met) next_st = RUN;
      end
      RUN: begin
        // The slot decision uses the pre-stop state, so a read still issues alongside stop.
        rd_req = slot && !bus.fifo_empty;
        if (bus.stop) begin
          next_st = DRAIN;
        end else if (slot && bus.fifo_empty) begin
          next_st  = PREFILL;
          underrun = 1'b1;
        end
      end
      DRAIN: begin
        rd_req = slot && !bus.fifo_empty;
        if (bus.stop || (slot && bus.fifo_empty)) next_st = IDLE;
      end
      default: next_st = IDLE;
    endcase
  end

  // Output registers are loaded from next_st so they change on the same edge as state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st               <= IDLE;
      phase            <= '0;
      bus.rd_en        <= 1'b0;
      bus.interp_ena   <= 1'b0;
      bus.dac_mute     <= 1'b1;
      bus.dac_sleep    <= 1'b1;
      bus.busy         <= 1'b0;
      bus.underrun_cnt <= '0;
      bus.overflow_cnt <= '0;
    end else begin
      st             <= next_st;
      bus.rd_en      <= rd_req;
      bus.interp_ena <= (next_st == RUN) || (next_st == DRAIN);
      bus.dac_mute   <= !((next_st == RUN) || (next_st == DRAIN));
      bus.dac_sleep  <= (next_st == IDLE);
      bus.busy       <= (next_st != IDLE);

      if ((next_st != st) || !((st == RUN) || (st == DRAIN)))
        phase <= '0;
      else
        phase <= phase + 1'b1;

      if (underrun && (bus.underrun_cnt != 8'hFF))
        bus.underrun_cnt <= bus.underrun_cnt + 8'd1;

      if (bus.wr_en && bus.fifo_full && (bus.overflow_cnt != 8'hFF))
        bus.overflow_cnt <= bus.overflow_cnt + 8'd1;
    end
  end

endmodule

// File: tb/tb_up_stream_ctrl.sv
// Directed bench for up_stream_ctrl: expected rd_en cycles go to a scoreboard queue,
// state/flag/counter values are checked with immediate assertions.
module tb_up_stream_ctrl;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  up_stream_ctrl_if #(.CNT_WIDTH(7)) bus ();

  up_stream_ctrl #(
    .FIFO_DEPTH   (64),
    .CNT_WIDTH    (7),
    .SAMPLE_RATE  (4),
    .PREFILL_LEVEL(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int unsigned cyc   = 0;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  int unsigned rd_q[$];
  int unsigned k, u, r, s;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int unsigned c);
    while (cyc < c) step();
  endtask

  task automatic check_reset(input string p);
    check({p, "_state"},    32'(bus.state),        32'd0);
    check({p, "_rd_en"},    32'(bus.rd_en),        32'd0);
    check({p, "_interp"},   32'(bus.interp_ena),   32'd0);
    check({p, "_mute"},     32'(bus.dac_mute),     32'd1);
    check({p, "_sleep"},    32'(bus.dac_sleep),    32'd1);
    check({p, "_busy"},     32'(bus.busy),         32'd0);
    check({p, "_underrun"}, 32'(bus.underrun_cnt), 32'd0);
    check({p, "_overflow"}, 32'(bus.overflow_cnt), 32'd0);
  endtask

  // Every rd_en pulse must match the next scheduled read cycle.
  always @(negedge clk) begin
    if (bus.rd_en === 1'b1) begin
      if (rd_q.size() == 0) check("rd_spurious", cyc, 32'd0);
      else                  check("rd_cycle", cyc, rd_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst            = 1'b1;
    bus.start      = 1'b0;
    bus.stop       = 1'b0;
    bus.fifo_count = '0;
    bus.fifo_empty = 1'b1;
    bus.fifo_full  = 1'b0;
    bus.wr_en      = 1'b0;
    step();
    step();
    check_reset("reset");
    rst = 1'b0;

    // Start with a well-filled FIFO: PREFILL then RUN, first read 16 cycles into RUN.
    wait_cyc(10);
    k = cyc;
    bus.fifo_count = 7'd40;
    bus.fifo_empty = 1'b0;
    bus.start      = 1'b1;
    rd_q.push_back(k + 18);
    rd_q.push_back(k + 34);
    rd_q.push_back(k + 50);
    step();
    bus.start = 1'b0;
    check("prefill_state", 32'(bus.state),     32'd1);
    check("prefill_mute",  32'(bus.dac_mute),  32'd1);
    check("prefill_sleep", 32'(bus.dac_sleep), 32'd0);
    step();
    check("run_state",  32'(bus.state),      32'd2);
    check("run_mute",   32'(bus.dac_mute),   32'd0);
    check("run_interp", 32'(bus.interp_ena), 32'd1);
    check("run_busy",   32'(bus.busy),       32'd1);

    // Empty glitch between slots must not count as underrun.
    wait_cyc(k + 36);
    bus.fifo_empty = 1'b1;
    step();
    step();
    bus.fifo_empty = 1'b0;

    // Empty at the slot: underrun, back to PREFILL, no read.
    wait_cyc(k + 60);
    bus.fifo_empty = 1'b1;
    bus.fifo_count = '0;
    wait_cyc(k + 66);
    u = cyc;
    check("underrun_state",  32'(bus.state),        32'd1);
    check("underrun_cnt",    32'(bus.underrun_cnt), 32'd1);
    check("underrun_mute",   32'(bus.dac_mute),     32'd1);
    check("underrun_interp", 32'(bus.interp_ena),   32'd0);

    // Exactly at the threshold re-enters RUN.
    bus.fifo_count = 7'd32;
    bus.fifo_empty = 1'b0;
    rd_q.push_back(u + 17);
    step();
    check("rerun_state", 32'(bus.state), 32'd2);

    // Stop with three words left: three drain reads, then IDLE at the empty slot.
    wait_cyc(u + 20);
    bus.stop       = 1'b1;
    bus.fifo_count = 7'd3;
    rd_q.push_back(u + 37);
    rd_q.push_back(u + 53);
    rd_q.push_back(u + 69);
    step();
    bus.stop = 1'b0;
    check("drain_state",  32'(bus.state),      32'd3);
    check("drain_mute",   32'(bus.dac_mute),   32'd0);
    check("drain_interp", 32'(bus.interp_ena), 32'd1);
    wait_cyc(u + 70);
    bus.fifo_empty = 1'b1;
    bus.fifo_count = '0;
    wait_cyc(u + 84);
    check("drain_last_slot", 32'(bus.state), 32'd3);
    step();
    check("drained_state",    32'(bus.state),        32'd0);
    check("drained_sleep",    32'(bus.dac_sleep),    32'd1);
    check("drained_busy",     32'(bus.busy),         32'd0);
    check("drained_interp",   32'(bus.interp_ena),   32'd0);
    check("drained_underrun", 32'(bus.underrun_cnt), 32'd1);

    // start+stop together in IDLE: stop wins.
    step();
    bus.fifo_count = 7'd40;
    bus.fifo_empty = 1'b0;
    bus.start      = 1'b1;
    bus.stop       = 1'b1;
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_idle_state", 32'(bus.state), 32'd0);
    check("ss_idle_busy",  32'(bus.busy),  32'd0);

    // start+stop together in RUN: goes to DRAIN, phase restarts there.
    step();
    r = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    check("r2_prefill_state", 32'(bus.state), 32'd1);
    step();
    check("r2_run_state", 32'(bus.state), 32'd2);
    wait_cyc(r + 5);
    bus.start = 1'b1;
    bus.stop  = 1'b1;
    rd_q.push_back(r + 22);
    step();
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    check("ss_run_state", 32'(bus.state), 32'd3);
    wait_cyc(r + 25);
    bus.stop = 1'b1;
    step();
    bus.stop = 1'b0;
    check("drain_stop_state", 32'(bus.state), 32'd0);

    // Overflow counter saturates at 255 while idle.
    bus.wr_en     = 1'b1;
    bus.fifo_full = 1'b1;
    repeat (254) step();
    check("overflow_254", 32'(bus.overflow_cnt), 32'd254);
    repeat (46) step();
    check("overflow_sat", 32'(bus.overflow_cnt), 32'd255);
    check("overflow_idle_state", 32'(bus.state), 32'd0);
    bus.wr_en     = 1'b0;
    bus.fifo_full = 1'b0;

    // Asynchronous reset landing on a slot: no read, everything back to reset values.
    s = cyc;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_cyc(s + 2);
    check("rst_pre_run", 32'(bus.state), 32'd2);
    wait_cyc(s + 17);
    rst = 1'b1;
    #1;
    check_reset("async");
    step();
    check("rst_held_rd_en", 32'(bus.rd_en), 32'd0);
    rst = 1'b0;
    repeat (5) step();
    check_reset("post_rst");

    repeat (3) step();
    check("rd_missing", 32'(rd_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
